// File: rtl/sipo_pkg.sv
// ---------------------------------------------------------------------------
// sipo_pkg
//   Shared definitions for the serial-to-parallel receiver:
//     state_t        receiver FSM states (IDLE, SHIFT, HOLD)
//     WIDTH_DEFAULT  default word length in bits
// ---------------------------------------------------------------------------
package sipo_pkg;

  localparam int WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage : sipo_pkg

// File: rtl/sipo_shift_reg.sv
// ---------------------------------------------------------------------------
// sipo_shift_reg
//   Partial-word register for the receiver. Each position loads the serial
//   bit when enabled and addressed. A clear load starts a new frame: bit 0
//   takes the serial bit and every other position is zeroed, so a partial
//   word from an aborted frame never leaks into the next one.
//
// Ports
//   clk    in   clock, rising edge
//   rst    in   asynchronous active-high reset, zeroes the word
//   en     in   load enable
//   clear  in   with en: start of frame (bit 0 <= din, others <= 0)
//   pos    in   with en and !clear: position that loads din
//   din    in   serial data bit
//   word   out  register contents
// ---------------------------------------------------------------------------
module sipo_shift_reg #(
  parameter int WIDTH = 3,
  parameter int PW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic [PW-1:0]    pos,
  input  logic             din,
  output logic [WIDTH-1:0] word
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          word[gi] <= 1'b0;
        end else if (en) begin
          if (clear) begin
            word[gi] <= (gi == 0) ? din : 1'b0;
          end else if (pos == PW'(gi)) begin
            word[gi] <= din;
          end
        end
      end
    end
  endgenerate

endmodule : sipo_shift_reg

// File: rtl/sipo_receiver.sv
// ---------------------------------------------------------------------------
// sipo_receiver
//   Collects a WIDTH-bit word sent LSB first on a strobed serial line,
//   together with the adder's final carry, and holds it for a consumer with
//   a ready handshake. A frame begins with in_start on bit 0; a premature
//   start aborts the current frame (frame_err) and a start arriving while a
//   word is still held is dropped (overrun). Both flags are sticky until rst.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   in_valid   in   serial bit strobe
//   in_bit     in   serial data bit, LSB first
//   in_start   in   current bit is bit 0 of a new frame
//   in_cout    in   final carry, sampled with the last bit
//   out_ready  in   consumer accepts the held word
//   out_data   out  assembled word
//   out_cout   out  carry captured with the word
//   out_valid  out  out_data/out_cout are valid and held
//   busy       out  a frame is being shifted in
//   overrun    out  sticky: a frame start was dropped while a word was held
//   frame_err  out  sticky: a frame was aborted by a premature start
// ---------------------------------------------------------------------------
module sipo_receiver
  import sipo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             in_start,
  input  logic             in_cout,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_cout,
  output logic             out_valid,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t              state, state_next;
  logic [CW-1:0]       cnt, cnt_next;
  logic                sr_en, sr_clear;
  logic                load_word;
  logic                set_overrun, set_frame_err;
  logic [WIDTH-2:0]    partial;

  // Only bits 0..WIDTH-2 are buffered; the last bit goes straight into
  // out_data together with the buffered ones.
  sipo_shift_reg #(
    .WIDTH (WIDTH - 1),
    .PW    (CW)
  ) u_shift (
    .clk   (clk),
    .rst   (rst),
    .en    (sr_en),
    .clear (sr_clear),
    .pos   (cnt),
    .din   (in_bit),
    .word  (partial)
  );

  // State and counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state, counter and control decode
  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    sr_en         = 1'b0;
    sr_clear      = 1'b0;
    load_word     = 1'b0;
    set_overrun   = 1'b0;
    set_frame_err = 1'b0;

    unique case (state)
      IDLE: begin
        // Non-start bits here belong to no frame and are dropped silently.
        if (in_valid && in_start) begin
          sr_en      = 1'b1;
          sr_clear   = 1'b1;
          cnt_next   = CW'(1);
          state_next = SHIFT;
        end
      end

      SHIFT: begin
        if (in_valid) begin
          if (in_start) begin
            // Abort and restart with this bit as bit 0.
            set_frame_err = 1'b1;
            sr_en         = 1'b1;
            sr_clear      = 1'b1;
            cnt_next      = CW'(1);
          end else if (cnt == LAST) begin
            load_word  = 1'b1;
            cnt_next   = '0;
            state_next = HOLD;
          end else begin
            sr_en    = 1'b1;
            cnt_next = cnt + CW'(1);
          end
        end
      end

      HOLD: begin
        if (out_ready) begin
          if (in_valid && in_start) begin
            // Release and start the next frame in the same cycle.
            sr_en      = 1'b1;
            sr_clear   = 1'b1;
            cnt_next   = CW'(1);
            state_next = SHIFT;
          end else begin
            state_next = IDLE;
          end
        end else if (in_valid && in_start) begin
          // No room for a new frame: drop it. Its remaining bits carry no
          // start and are ignored in HOLD and IDLE.
          set_overrun = 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Output word, carry and sticky flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_cout  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (load_word) begin
        out_data <= {in_bit, partial};
        out_cout <= in_cout;
      end
      if (set_overrun) begin
        overrun <= 1'b1;
      end
      if (set_frame_err) begin
        frame_err <= 1'b1;
      end
    end
  end

  assign busy      = (state == SHIFT);
  assign out_valid = (state == HOLD);

endmodule : sipo_receiver

// File: tb/tb_sipo_receiver.sv
// ---------------------------------------------------------------------------
// tb_sipo_receiver
//   Directed frames followed by random traffic for sipo_receiver (WIDTH=4).
//   The reference model collects frame bits in a queue and forms the word
//   arithmetically once WIDTH bits have arrived.
// ---------------------------------------------------------------------------
module tb_sipo_receiver;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_bit = 1'b0;
  logic         in_start = 1'b0;
  logic         in_cout = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         out_cout;
  logic         out_valid;
  logic         busy;
  logic         overrun;
  logic         frame_err;

  always #5 clk = ~clk;

  sipo_receiver #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .in_start  (in_start),
    .in_cout   (in_cout),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_cout  (out_cout),
    .out_valid (out_valid),
    .busy      (busy),
    .overrun   (overrun),
    .frame_err (frame_err)
  );

  // Reference model
  bit           q[$];
  bit           m_held, m_frame, m_ovr, m_ferr, m_cout;
  int unsigned  m_word;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    q.delete();
    m_held  = 0;
    m_frame = 0;
    m_ovr   = 0;
    m_ferr  = 0;
    m_cout  = 0;
    m_word  = 0;
  endtask

  task automatic start_frame(input bit b);
    q.delete();
    q.push_back(b);
    m_frame = 1;
  endtask

  task automatic model_step(input bit v, input bit b, input bit s, input bit c, input bit r);
    if (m_held) begin
      if (r) begin
        m_held = 0;
        if (v && s) start_frame(b);
      end else if (v && s) begin
        m_ovr = 1;
      end
    end else if (m_frame) begin
      if (v) begin
        if (s) begin
          m_ferr = 1;
          start_frame(b);
        end else begin
          q.push_back(b);
          if (q.size() == W) begin
            m_word = 0;
            foreach (q[i]) m_word += int'(q[i]) << i;
            m_cout  = c;
            m_held  = 1;
            m_frame = 0;
            q.delete();
          end
        end
      end
    end else if (v && s) begin
      start_frame(b);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".out_valid"}, out_valid, m_held);
    chk({tag, ".busy"},      busy,      m_frame);
    chk({tag, ".overrun"},   overrun,   m_ovr);
    chk({tag, ".frame_err"}, frame_err, m_ferr);
    if (m_held) begin
      chk({tag, ".out_data"}, out_data, m_word);
      chk({tag, ".out_cout"}, out_cout, m_cout);
    end
  endtask

  // One clock of stimulus; outputs checked 1 time unit after the edge.
  task automatic step(input string tag, input bit v, input bit b, input bit s,
                      input bit c, input bit r);
    in_valid  = v;
    in_bit    = b;
    in_start  = s;
    in_cout   = c;
    out_ready = r;
    @(posedge clk);
    model_step(v, b, s, c, r);
    #1;
    check_outputs(tag);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".out_data"},  out_data,  0);
    chk({tag, ".out_cout"},  out_cout,  0);
    chk({tag, ".out_valid"}, out_valid, 0);
    chk({tag, ".busy"},      busy,      0);
    chk({tag, ".overrun"},   overrun,   0);
    chk({tag, ".frame_err"}, frame_err, 0);
  endtask

  // Asserted between edges: outputs must clear before any clock edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_zero(tag);
    model_reset();
    in_valid  = 0;
    out_ready = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Frame 1,0,1,1 with carry 1 -> 4'hD held.
  task automatic frame_d(input string tag);
    step(tag, 1, 1, 1, 0, 0);
    step(tag, 1, 0, 0, 0, 0);
    step(tag, 1, 1, 0, 0, 0);
    step(tag, 1, 1, 0, 1, 0);
  endtask

  initial begin
    model_reset();
    #2;
    check_zero("por");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    step("idle", 0, 0, 0, 0, 0);
    step("idle_nostart", 1, 1, 0, 1, 0);

    // Basic frame, one-cycle latency
    step("basic", 1, 1, 1, 0, 0);
    step("basic", 1, 0, 0, 0, 0);
    step("basic", 1, 1, 0, 0, 0);
    chk("basic.pre_valid", out_valid, 0);
    step("basic", 1, 1, 0, 1, 0);
    chk("basic.data", out_data, 4'hD);
    chk("basic.cout", out_cout, 1);
    chk("basic.valid", out_valid, 1);
    step("basic_rel", 0, 0, 0, 0, 1);

    // Gapped frame: valid every third cycle
    step("gap", 1, 1, 1, 0, 0);
    for (int k = 1; k < W; k++) begin
      step("gap_idle", 0, 1'($urandom), 1'($urandom), 0, 0);
      chk("gap.busy", busy, 1);
      step("gap_idle", 0, 1'($urandom), 1'($urandom), 0, 0);
      step("gap", 1, (k != 1), 0, (k == W - 1), 0);
    end
    chk("gap.data", out_data, 4'hD);
    chk("gap.cout", out_cout, 1);
    step("gap_rel", 0, 0, 0, 0, 1);

    // Overrun while held
    frame_d("ovr");
    step("ovr_start", 1, 1, 1, 0, 0);
    chk("ovr.flag", overrun, 1);
    chk("ovr.data", out_data, 4'hD);
    step("ovr_trail", 1, 1, 0, 0, 0);
    step("ovr_trail", 1, 0, 0, 0, 0);
    step("ovr_rel", 0, 0, 0, 0, 1);
    chk("ovr.idle", out_valid, 0);
    step("ovr_trail2", 1, 1, 0, 0, 0);
    chk("ovr.nobusy", busy, 0);

    // Release and restart in the same cycle: frame 0,1,1,0
    frame_d("b2b");
    step("b2b", 1, 0, 1, 0, 1);
    chk("b2b.busy", busy, 1);
    step("b2b", 1, 1, 0, 0, 0);
    step("b2b", 1, 1, 0, 0, 0);
    step("b2b", 1, 0, 0, 0, 0);
    chk("b2b.data", out_data, 4'h6);
    chk("b2b.cout", out_cout, 0);
    step("b2b_rel", 0, 0, 0, 0, 1);

    // Premature start: aborted frame, then 0,0,0,1
    step("ferr", 1, 1, 1, 0, 0);
    step("ferr", 1, 1, 0, 0, 0);
    step("ferr", 1, 1, 0, 0, 0);
    step("ferr", 1, 0, 1, 0, 0);
    chk("ferr.flag", frame_err, 1);
    step("ferr", 1, 0, 0, 0, 0);
    step("ferr", 1, 0, 0, 0, 0);
    step("ferr", 1, 1, 0, 1, 0);
    chk("ferr.data", out_data, 4'h8);
    step("ferr_rel", 0, 0, 0, 0, 1);

    // Reset mid-frame, trailing bits ignored
    step("rstmid", 1, 1, 1, 0, 0);
    step("rstmid", 1, 1, 0, 0, 0);
    do_reset("rstmid");
    step("rst_trail", 1, 1, 0, 1, 0);
    step("rst_trail", 1, 1, 0, 1, 0);
    chk("rst_trail.busy", busy, 0);
    chk("rst_trail.valid", out_valid, 0);

    // Reset while holding a word
    frame_d("rsthold");
    do_reset("rsthold");
    step("rsthold_after", 0, 0, 0, 0, 0);

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset("rnd_rst");
      end else begin
        step("rnd",
             ($urandom_range(0, 2) != 0),
             1'($urandom),
             ($urandom_range(0, 5) == 0),
             1'($urandom),
             ($urandom_range(0, 3) == 0));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog: every step is clock-bounded, this only guards a stuck clock.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule : tb_sipo_receiver

// File: doc/sipo_receiver.md
SIPO_RECEIVER -- requirements
Module: sipo_receiver

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning word length in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  serial bit strobe; in_bit, in_start and in_cout are sampled only when 1.
REQ-005 SHALL have port in_bit  input  1  serial data bit, LSB first.
REQ-006 SHALL have port in_start  input  1  marks the current bit as bit 0 of a new frame.
REQ-007 SHALL have port in_cout  input  1  final carry of the serial adder; sampled with the last bit of the frame.
REQ-008 SHALL have port out_ready  input  1  consumer accepts the held word.
REQ-009 SHALL have port out_data  output  WIDTH  assembled word.
REQ-010 SHALL have port out_cout  output  1  carry captured with the word.
REQ-011 SHALL have port out_valid  output  1  out_data/out_cout are valid and held.
REQ-012 SHALL have port busy  output  1  a frame is being shifted in.
REQ-013 SHALL have port overrun  output  1  sticky: a frame start was dropped while a word was held.
REQ-014 SHALL have port frame_err  output  1  sticky: a frame was aborted by a premature in_start.

Function
REQ-015 SHALL implement states IDLE, SHIFT and HOLD; busy=1 only in SHIFT, out_valid=1 only in HOLD.
REQ-016 In IDLE, in_valid=1 with in_start=1 SHALL store in_bit at bit 0, set the bit count to 1, and go to SHIFT.
REQ-017 In IDLE, in_valid=1 with in_start=0 SHALL be ignored, with no state or flag change.
REQ-018 In SHIFT, each in_valid=1 with in_start=0 SHALL store in_bit at the bit position equal to the bit count, then increment the count.
REQ-019 The bit with count WIDTH-1 SHALL capture in_cout into out_cout, load out_data, and go to HOLD; out_valid rises the cycle after the last bit is sampled (1-cycle latency).
REQ-020 In SHIFT, in_valid=1 with in_start=1 SHALL set frame_err, discard the partial word, and restart the frame with this bit as bit 0.
REQ-021 In SHIFT, in_valid=0 cycles SHALL hold all state; there is no timeout.
REQ-022 In HOLD, out_data/out_cout SHALL stay stable until out_ready=1, then go to IDLE.
REQ-023 In HOLD, out_ready=1 with in_valid=1 and in_start=1 in the same cycle SHALL release the word and accept the bit as bit 0, going directly to SHIFT with no lost bit.
REQ-024 In HOLD, out_ready=0 with in_valid=1 and in_start=1 SHALL set overrun and drop the bit; any later non-start bits of that frame are ignored.
REQ-025 For WIDTH=2..32, the bit counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL never wrap past WIDTH-1.
REQ-026 overrun and frame_err SHALL clear only on rst.

Reset
REQ-027 rst=1 SHALL force IDLE, bit count 0, out_data=0, out_cout=0, out_valid=0, busy=0, overrun=0, frame_err=0, immediately and asynchronously.
REQ-028 rst asserted mid-frame or in HOLD SHALL discard the partial or held word; the first frame after rst deasserts requires a new in_start.

Structure
REQ-029 Package sipo_pkg SHALL hold the state enum (IDLE, SHIFT, HOLD) and the WIDTH default constant.
REQ-030 A single sub-module sipo_shift_reg SHALL hold the enable-gated, asynchronously reset data register with a per-position load; the FSM, counter and flags stay in sipo_receiver.

Verification (WIDTH=4)
REQ-031 Frame bits 1,0,1,1 with start on the first bit and in_cout=1 on the last -> out_data=4'hD, out_cout=1, out_valid one cycle after the last bit.
REQ-032 Same frame with in_valid gapped (valid every 3rd cycle) -> identical result; busy=1 throughout the gaps.
REQ-033 Word held with out_ready=0, then a new start bit=1 -> overrun=1, out_data stays 4'hD; out_ready=1 then releases to IDLE.
REQ-034 Held word, out_ready=1 in the same cycle as start bit 0 of frame 0,1,1,0 -> first word consumed, next out_data=4'h6, no bit lost.
REQ-035 Start, 2 bits, then a second start and 4 bits 0,0,0,1 -> frame_err=1, out_data=4'h8.
REQ-036 rst pulse after 2 bits of a frame -> all outputs 0 within the same cycle; trailing bits without in_start are ignored.
